// File: rtl/rvic_claim_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rvic_claim_ctrl
//  Purpose  : Claim/complete controller for a small vectored interrupt
//             controller. Raises irq_o for an eligible candidate, answers CPU
//             claims with the claimed ID (or 8'hFF), clears the pending bit of
//             a claimed source, and tracks nested active interrupts on a LIFO
//             stack of {id, prio} entries.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NEST_DEPTH     maximum number of nested active interrupts (1..8)
//  Configuration macro
//    RVIC_NEST_EN   defined   : preemption enabled, stack depth NEST_DEPTH
//                   undefined : effective depth forced to 1 (no nesting)
//  Ports
//    clk_i          clock, rising edge
//    rst_ni         asynchronous active-low reset
//    cand_id_i      ID of the highest-priority enabled pending source
//    cand_prio_i    priority of cand_id_i (0 = no request)
//    threshold_i    global priority threshold
//    claim_i        single-cycle claim strobe
//    complete_i     single-cycle complete strobe
//    complete_id_i  ID being completed
//    irq_o          interrupt request to the CPU
//    claim_rvalid_o claim response valid pulse
//    claim_id_o     claimed ID, 8'hFF when nothing eligible
//    pend_clr_o     pending-clear pulse to the interrupt core
//    pend_clr_id_o  ID whose pending bit is cleared
//    complete_err_o pulse on an illegal complete
//    active_prio_o  priority on top of the stack (0 when empty)
//    depth_o        current stack occupancy
// ============================================================================
module rvic_claim_ctrl #(
  parameter int NEST_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [4:0] cand_id_i,
  input  logic [7:0] cand_prio_i,
  input  logic [7:0] threshold_i,
  input  logic       claim_i,
  input  logic       complete_i,
  input  logic [4:0] complete_id_i,
  output logic       irq_o,
  output logic       claim_rvalid_o,
  output logic [7:0] claim_id_o,
  output logic       pend_clr_o,
  output logic [4:0] pend_clr_id_o,
  output logic       complete_err_o,
  output logic [7:0] active_prio_o,
  output logic [3:0] depth_o
);

  localparam int c_aw = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
`ifdef RVIC_NEST_EN
  localparam int c_eff_depth = NEST_DEPTH;
`else
  localparam int c_eff_depth = 1;
`endif
  localparam logic [3:0] c_eff_depth_w = 4'(c_eff_depth);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t          r_state;
  logic [4:0]      r_stk_id   [NEST_DEPTH];
  logic [7:0]      r_stk_prio [NEST_DEPTH];
  logic [3:0]      r_depth;
  logic            r_claim_pend;
  logic            r_claim_rvalid;
  logic [7:0]      r_claim_id;
  logic            r_pend_clr;
  logic [4:0]      r_pend_clr_id;
  logic            r_complete_err;

  logic [c_aw-1:0] w_top_idx;
  logic [c_aw-1:0] w_wr_idx;
  logic [7:0]      w_active_prio;
  logic            w_eligible;
  logic            w_claim_ok;
  logic            w_claim_latch;
  logic            w_claim_svc;
  logic            w_pop;
  logic            w_push;
  logic            w_cerr;

  assign w_top_idx     = c_aw'(r_depth - 4'd1);
  assign w_active_prio = (r_depth == 4'd0) ? 8'd0 : r_stk_prio[w_top_idx];

  assign w_eligible = (cand_prio_i > threshold_i) &&
                      (cand_prio_i > w_active_prio) &&
                      (r_depth < c_eff_depth_w);

  // A claim is only accepted outside RESP and when no claim is already held
  // over from a claim+complete collision.
  assign w_claim_ok    = claim_i && (r_state != ST_RESP) && !r_claim_pend;
  // Collision with complete: let the pop land first, answer one cycle later.
  assign w_claim_latch = w_claim_ok && complete_i;
  assign w_claim_svc   = r_claim_pend || (w_claim_ok && !complete_i);

  assign w_pop  = complete_i && (r_depth != 4'd0) &&
                  (complete_id_i == r_stk_id[w_top_idx]);
  assign w_cerr = complete_i && !w_pop;
  assign w_push = w_claim_svc && w_eligible;

  // Push slot accounts for a simultaneous pop so the stack stays contiguous.
  assign w_wr_idx = c_aw'(r_depth - {3'b000, w_pop});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= ST_IDLE;
      r_depth        <= 4'd0;
      r_claim_pend   <= 1'b0;
      r_claim_rvalid <= 1'b0;
      r_claim_id     <= 8'h00;
      r_pend_clr     <= 1'b0;
      r_pend_clr_id  <= 5'd0;
      r_complete_err <= 1'b0;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        r_stk_id[i]   <= 5'd0;
        r_stk_prio[i] <= 8'd0;
      end
    end else begin
      r_pend_clr     <= 1'b0;
      r_claim_rvalid <= 1'b0;
      r_complete_err <= w_cerr;
      r_claim_pend   <= w_claim_latch;
      r_depth        <= r_depth - {3'b000, w_pop} + {3'b000, w_push};

      if (w_push) begin
        r_stk_id[w_wr_idx]   <= cand_id_i;
        r_stk_prio[w_wr_idx] <= cand_prio_i;
        r_pend_clr           <= 1'b1;
        r_pend_clr_id        <= cand_id_i;
      end

      if (w_claim_svc) begin
        r_claim_rvalid <= 1'b1;
        r_claim_id     <= w_eligible ? {3'b000, cand_id_i} : 8'hFF;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_claim_svc)        r_state <= ST_RESP;
          else if (w_claim_latch) r_state <= ST_IDLE;
          else if (w_eligible)    r_state <= ST_ASSERT;
        end
        ST_ASSERT: begin
          if (w_claim_svc)        r_state <= ST_RESP;
          else if (w_claim_latch) r_state <= ST_IDLE;
          else if (!w_eligible)   r_state <= ST_IDLE;
        end
        ST_RESP:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign irq_o          = (r_state == ST_ASSERT);
  assign claim_rvalid_o = r_claim_rvalid;
  assign claim_id_o     = r_claim_id;
  assign pend_clr_o     = r_pend_clr;
  assign pend_clr_id_o  = r_pend_clr_id;
  assign complete_err_o = r_complete_err;
  assign active_prio_o  = w_active_prio;
  assign depth_o        = r_depth;

endmodule
`default_nettype wire

// File: tb/tb_rvic_claim_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rvic_claim_ctrl
//  Purpose  : Scoreboard bench for rvic_claim_ctrl. Directed scenarios and
//             random traffic feed a queue-based reference model; a monitor
//             compares every response pulse and the per-cycle state outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rvic_claim_ctrl;

  localparam int NEST_DEPTH = 4;
`ifdef RVIC_NEST_EN
  localparam int EFF = NEST_DEPTH;
`else
  localparam int EFF = 1;
`endif

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [4:0] cand_id_i = '0;
  logic [7:0] cand_prio_i = '0;
  logic [7:0] threshold_i = '0;
  logic       claim_i = 1'b0;
  logic       complete_i = 1'b0;
  logic [4:0] complete_id_i = '0;
  logic       irq_o, claim_rvalid_o, pend_clr_o, complete_err_o;
  logic [7:0] claim_id_o, active_prio_o;
  logic [4:0] pend_clr_id_o;
  logic [3:0] depth_o;

  rvic_claim_ctrl #(.NEST_DEPTH(NEST_DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cand_id_i(cand_id_i),
    .cand_prio_i(cand_prio_i), .threshold_i(threshold_i), .claim_i(claim_i),
    .complete_i(complete_i), .complete_id_i(complete_id_i), .irq_o(irq_o),
    .claim_rvalid_o(claim_rvalid_o), .claim_id_o(claim_id_o),
    .pend_clr_o(pend_clr_o), .pend_clr_id_o(pend_clr_id_o),
    .complete_err_o(complete_err_o), .active_prio_o(active_prio_o),
    .depth_o(depth_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int cyc = 0;
  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d (0x%0h), expected %0d (0x%0h)",
               nm, cyc, act, act, exp, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; int val; } exp_t;
  exp_t q_resp[$];
  exp_t q_clr[$];
  int   q_err[$];

  int   m_id[$];      // stack of active IDs, top at the end
  int   m_prio[$];    // matching priorities
  int   m_mode = 0;   // 0 idle, 1 requesting, 2 answering
  bit   m_latched = 0;

  function automatic int m_active();
    return (m_prio.size() > 0) ? m_prio[m_prio.size()-1] : 0;
  endfunction

  task automatic model_clear();
    m_id.delete(); m_prio.delete();
    q_resp.delete(); q_clr.delete(); q_err.delete();
    m_mode = 0; m_latched = 0;
  endtask

  // Computes what the next rising edge does with the inputs now applied.
  task automatic model_step();
    bit elig, claim_ok, svc, latch;
    elig = (int'(cand_prio_i) > int'(threshold_i)) &&
           (int'(cand_prio_i) > m_active()) && (m_id.size() < EFF);
    claim_ok = claim_i && (m_mode != 2) && !m_latched;
    svc      = m_latched || (claim_ok && !complete_i);
    latch    = claim_ok && complete_i;
    if (complete_i) begin
      if (m_id.size() > 0 && m_id[m_id.size()-1] == int'(complete_id_i)) begin
        void'(m_id.pop_back());
        void'(m_prio.pop_back());
      end else begin
        q_err.push_back(cyc + 1);
      end
    end
    if (svc) begin
      if (elig) begin
        m_id.push_back(int'(cand_id_i));
        m_prio.push_back(int'(cand_prio_i));
        q_clr.push_back('{cyc + 1, int'(cand_id_i)});
        q_resp.push_back('{cyc + 1, int'(cand_id_i)});
      end else begin
        q_resp.push_back('{cyc + 1, 255});
      end
      m_mode = 2;
    end else if (latch) begin
      m_mode = 0;
    end else if (m_mode == 2) begin
      m_mode = 0;
    end else begin
      m_mode = elig ? 1 : 0;
    end
    m_latched = latch;
  endtask

  task automatic drive(input int id, input int pr, input int th,
                       input bit cl, input bit co, input int cid);
    @(negedge clk_i);
    #1;
    rst_ni        = 1'b1;
    cand_id_i     = 5'(id);
    cand_prio_i   = 8'(pr);
    threshold_i   = 8'(th);
    claim_i       = m_latched ? 1'b0 : cl;
    complete_i    = m_latched ? 1'b0 : co;
    complete_id_i = 5'(cid);
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 2, 0, 0, 0);
  endtask

  // Reset asserted mid-cycle together with claim and complete strobes.
  task automatic pulse_reset();
    @(negedge clk_i);
    #1;
    rst_ni     = 1'b0;
    claim_i    = 1'b1;
    complete_i = 1'b1;
    #1;
    chk("reset_depth_now", int'(depth_o), 0);
    chk("reset_irq_now", int'(irq_o), 0);
    model_clear();
  endtask

  // ---------------- monitor ----------------
  initial forever begin
    exp_t e;
    @(negedge clk_i);
    chk("irq_o", int'(irq_o), (m_mode == 1) ? 1 : 0);
    chk("depth_o", int'(depth_o), m_id.size());
    chk("active_prio_o", int'(active_prio_o), m_active());
    if (!rst_ni) begin
      chk("reset_claim_id_o", int'(claim_id_o), 0);
      chk("reset_pend_clr_id_o", int'(pend_clr_id_o), 0);
    end
    if (claim_rvalid_o) begin
      if (q_resp.size() == 0) chk("claim_rvalid_unexpected", int'(claim_rvalid_o), 0);
      else begin
        e = q_resp.pop_front();
        chk("claim_resp_cycle", cyc, e.due);
        chk("claim_id_o", int'(claim_id_o), e.val);
      end
    end else if (q_resp.size() > 0 && q_resp[0].due <= cyc) begin
      chk("claim_resp_missing_at", cyc - 1, q_resp[0].due);
      void'(q_resp.pop_front());
    end
    if (pend_clr_o) begin
      if (q_clr.size() == 0) chk("pend_clr_unexpected", int'(pend_clr_o), 0);
      else begin
        e = q_clr.pop_front();
        chk("pend_clr_cycle", cyc, e.due);
        chk("pend_clr_id_o", int'(pend_clr_id_o), e.val);
      end
    end else if (q_clr.size() > 0 && q_clr[0].due <= cyc) begin
      chk("pend_clr_missing_at", cyc - 1, q_clr[0].due);
      void'(q_clr.pop_front());
    end
    if (complete_err_o) begin
      if (q_err.size() == 0) chk("complete_err_unexpected", int'(complete_err_o), 0);
      else chk("complete_err_cycle", cyc, q_err.pop_front());
    end else if (q_err.size() > 0 && q_err[0] <= cyc) begin
      chk("complete_err_missing_at", cyc - 1, q_err[0]);
      void'(q_err.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int id, pr, th, cid;
    bit cl, co;
    repeat (3) @(negedge clk_i);
    // Single interrupt: id 5 prio 3 over threshold 2, then claim it.
    drive(5, 3, 2, 0, 0, 0);
    drive(5, 3, 2, 0, 0, 0);
    drive(5, 3, 2, 1, 0, 0);
    idle(2);
    // Equal priority candidate must not preempt; claim returns 8'hFF.
    drive(7, 3, 2, 0, 0, 0);
    drive(7, 3, 2, 0, 0, 0);
    drive(7, 3, 2, 1, 0, 0);
    idle(2);
    // Higher-priority nested candidate, then unwind.
    drive(9, 7, 2, 0, 0, 0);
    drive(9, 7, 2, 0, 0, 0);
    drive(9, 7, 2, 1, 0, 0);
    idle(2);
    drive(0, 0, 2, 0, 1, 9);
    drive(0, 0, 2, 0, 1, 5);
    idle(2);
    // Wrong-ID complete while 5 is on top.
    drive(5, 3, 2, 1, 0, 0);
    idle(2);
    drive(0, 0, 2, 0, 1, 4);
    idle(2);
    // Claim and complete collide: pop 5 first, answer 9 two cycles later.
    drive(9, 7, 2, 1, 1, 5);
    drive(9, 7, 2, 0, 0, 0);
    idle(3);
    drive(0, 0, 2, 0, 1, 9);
    idle(2);
    // Build up nesting, then reset in the middle of it.
    drive(1, 3, 0, 1, 0, 0);
    drive(2, 5, 0, 0, 0, 0);
    drive(2, 5, 0, 1, 0, 0);
    drive(3, 7, 0, 0, 0, 0);
    drive(3, 7, 0, 1, 0, 0);
    drive(4, 9, 0, 0, 0, 0);
    pulse_reset();
    idle(3);
    // Randomised traffic.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        pulse_reset();
        continue;
      end
      id  = int'($urandom_range(0, 31));
      pr  = int'($urandom_range(0, 12));
      th  = int'($urandom_range(0, 4));
      cl  = ($urandom_range(0, 9) < 3);
      co  = ($urandom_range(0, 9) < 2);
      cid = (m_id.size() > 0 && $urandom_range(0, 3) != 0) ?
            m_id[m_id.size()-1] : int'($urandom_range(0, 31));
      drive(id, pr, th, cl, co, cid);
    end
    idle(6);
    chk("resp_queue_drained", q_resp.size(), 0);
    chk("clr_queue_drained", q_clr.size(), 0);
    chk("err_queue_drained", q_err.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rvic_claim_ctrl.md
RVIC_CLAIM_CTRL -- requirements
Module: rvic_claim_ctrl

Interface
REQ-001 SHALL have parameter NEST_DEPTH, default 4, meaning the maximum number of nested active interrupts (legal range 1..8).
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cand_id_i  input  5  ID of the highest-priority enabled pending source from the interrupt core.
REQ-005 SHALL have port cand_prio_i  input  8  priority of cand_id_i; 0 means no request.
REQ-006 SHALL have port threshold_i  input  8  global priority threshold.
REQ-007 SHALL have port claim_i  input  1  single-cycle CPU claim strobe.
REQ-008 SHALL have port complete_i  input  1  single-cycle CPU complete strobe.
REQ-009 SHALL have port complete_id_i  input  5  ID being completed.
REQ-010 SHALL have port irq_o  output  1  interrupt request to the CPU.
REQ-011 SHALL have port claim_rvalid_o  output  1  claim response valid pulse.
REQ-012 SHALL have port claim_id_o  output  8  claimed ID, or 8'hFF when none.
REQ-013 SHALL have port pend_clr_o  output  1  single-cycle pending-clear pulse to the interrupt core.
REQ-014 SHALL have port pend_clr_id_o  output  5  ID whose pending bit is cleared.
REQ-015 SHALL have port complete_err_o  output  1  pulse on an illegal complete.
REQ-016 SHALL have port active_prio_o  output  8  priority on top of the nesting stack (0 when empty).
REQ-017 SHALL have port depth_o  output  4  current stack occupancy.

Function
REQ-018 SHALL hold a LIFO stack of {id[4:0], prio[7:0]} entries of depth NEST_DEPTH.
REQ-019 SHALL compute eligible = (cand_prio_i > threshold_i) && (cand_prio_i > active_prio_o) && (depth_o < NEST_DEPTH); comparisons are unsigned, 8-bit.
REQ-020 SHALL implement the FSM states IDLE, ASSERT and RESP.
REQ-021 SHALL transition IDLE->ASSERT when eligible and !claim_i.
REQ-022 SHALL transition ASSERT->IDLE when !eligible; the request is then withdrawn without a response.
REQ-023 SHALL transition from IDLE or ASSERT to RESP on an accepted claim_i, and RESP->IDLE unconditionally after one cycle.
REQ-024 SHALL drive irq_o high only in ASSERT, i.e. one cycle after eligible is first seen.
REQ-025 On an accepted claim in cycle N with eligible true, SHALL push {cand_id_i, cand_prio_i} and assert pend_clr_o with pend_clr_id_o=cand_id_i in cycle N+1.
REQ-026 In the same case, SHALL assert claim_rvalid_o with claim_id_o={3'b0,cand_id_i} in cycle N+1.
REQ-027 On an accepted claim with eligible false (including stack full), SHALL return claim_id_o=8'hFF with claim_rvalid_o in N+1, with no push and no pend_clr_o.
REQ-028 SHALL ignore claim_i while in RESP (no response, no push).
REQ-029 On complete_i with complete_id_i equal to the top-entry ID and depth>0, SHALL pop one entry, effective the next cycle.
REQ-030 On complete_i with an ID mismatch or an empty stack, SHALL pulse complete_err_o the next cycle and leave the stack unchanged.
REQ-031 When claim_i and complete_i arrive in the same cycle, SHALL apply complete first, latch the claim, and service the claim the following cycle against the post-pop state (response latency 2).
REQ-032 SHALL register pend_clr_o, claim_rvalid_o and complete_err_o, each high for exactly one cycle per event.
REQ-033 SHALL update active_prio_o and depth_o combinationally from the registered stack state.

Reset
REQ-034 On rst_ni low, SHALL enter IDLE, empty the stack and clear any latched claim, regardless of in-flight operations.
REQ-035 SHALL drive all outputs to 0 in reset, except claim_id_o=8'h00.
REQ-036 SHALL give no response to a claim or complete issued in the cycle reset asserts.

Configuration
REQ-037 Macro RVIC_NEST_EN: when defined, SHALL support preemption with the stack depth given by NEST_DEPTH.
REQ-038 When RVIC_NEST_EN is undefined, SHALL force the effective depth to 1, so irq_o stays low while any interrupt is active and a nested claim returns 8'hFF.

Verification
REQ-039 SHALL cover: threshold=2, cand id=5 prio=3 -> irq_o high after 1 cycle; claim -> claim_id_o=8'h05, pend_clr_id_o=5, depth_o=1, active_prio_o=3.
REQ-040 SHALL cover: with id5 prio3 active, cand id=9 prio=7 -> irq_o high; claim -> 8'h09, depth_o=2; complete 9 then complete 5 -> depth_o=0.
REQ-041 SHALL cover: with id5 prio3 active, cand prio=3 -> irq_o stays low; a claim returns 8'hFF and produces no pend_clr_o.
REQ-042 SHALL cover: complete_id_i=4 while the top entry is 5 -> complete_err_o pulse, depth_o unchanged.
REQ-043 SHALL cover: claim and complete on the same cycle -> pop first, claim response 2 cycles later with the correct ID.
REQ-044 SHALL cover: rst_ni pulsed at depth 3 -> depth_o=0 and irq_o=0 immediately; and with RVIC_NEST_EN undefined, a nested higher-priority candidate gives irq_o=0.
